// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 8:1 mux scan sequencer.
package mux_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } scan_state_t;

endpackage

// File: rtl/mux_next_chan.sv
// Priority finder: lowest enabled channel above cur, or lowest enabled overall when first=1.
module mux_next_chan
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              first,
    output logic [SEL_W-1:0]  nxt,
    output logic              found
);

    logic [NUM_CH-1:0] cand;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
            assign cand[gi] = mask[gi] && (first || (SEL_W'(gi) > cur));
        end
    endgenerate

    // Scan from the top down so the lowest candidate is the last one written.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 mux: steps the select over enabled channels,
// waits a settle time per channel, samples y_in and publishes a byte with a valid pulse.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_CH        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              y_in,
    output logic [2:0]        sel,
    output logic [NUM_CH-1:0] data_out,
    output logic              valid,
    output logic              busy
);

    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

    scan_state_t       state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [NUM_CH-1:0] mask_reg, mask_next;
    logic [NUM_CH-1:0] shadow_reg, shadow_next;
    logic [2:0]        sel_reg, sel_next;
    logic [NUM_CH-1:0] data_reg, data_next;

    logic [NUM_CH-1:0] find_mask;
    logic              find_first;
    logic [2:0]        nxt_ch;
    logic              nxt_found;

    mux_next_chan u_next_chan (
        .mask  (find_mask),
        .cur   (sel_reg),
        .first (find_first),
        .nxt   (nxt_ch),
        .found (nxt_found)
    );

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mask_next   = mask_reg;
        shadow_next = shadow_reg;
        sel_next    = sel_reg;
        data_next   = data_reg;
        find_mask   = mask_reg;
        find_first  = 1'b0;

        case (state_reg)
            IDLE: begin
                find_mask  = ch_mask;
                find_first = 1'b1;
                sel_next   = '0;
                if (start) begin
                    mask_next   = ch_mask;
                    shadow_next = '0;
                    if (nxt_found) begin
                        state_next = SETTLE;
                        sel_next   = nxt_ch;
                        cnt_next   = CNT_RELOAD;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_reg == 4'd0) begin
                    // An empty mask only reaches SETTLE via a continuous restart;
                    // the settle period then spaces consecutive valid pulses.
                    state_next = (mask_reg == '0) ? DONE : SAMPLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            SAMPLE: begin
                shadow_next[sel_reg] = y_in;
                if (nxt_found) begin
                    state_next = SETTLE;
                    sel_next   = nxt_ch;
                    cnt_next   = CNT_RELOAD;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (cont) begin
                    find_mask   = ch_mask;
                    find_first  = 1'b1;
                    mask_next   = ch_mask;
                    shadow_next = '0;
                    state_next  = SETTLE;
                    sel_next    = nxt_found ? nxt_ch : 3'd0;
                    cnt_next    = CNT_RELOAD;
                end else begin
                    state_next = IDLE;
                    sel_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase

        // data_out loads on entry to DONE, including the bit sampled on that same edge.
        if (state_next == DONE && state_reg != DONE) begin
            data_next = shadow_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            mask_reg   <= '0;
            shadow_reg <= '0;
            sel_reg    <= '0;
            data_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            mask_reg   <= mask_next;
            shadow_reg <= shadow_next;
            sel_reg    <= sel_next;
            data_reg   <= data_next;
        end
    end

    assign sel      = sel_reg;
    assign data_out = data_reg;
    assign valid    = (state_reg == DONE);
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: stimulus pushes expected bytes and valid cycles,
// a negedge monitor pops and compares on every valid pulse.
module tb_mux_scan_ctrl;

    localparam int S    = 2;
    localparam int STEP = S + 1;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [7:0] ch_mask = 8'h00;
    logic       y_in;
    logic [2:0] sel;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;

    logic [7:0] pat = 8'h00;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       prev_valid = 1'b0;
    exp_t       sb_q[$];

    mux_scan_ctrl #(.SETTLE_CYCLES(S), .NUM_CH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cont     (cont),
        .ch_mask  (ch_mask),
        .y_in     (y_in),
        .sel      (sel),
        .data_out (data_out),
        .valid    (valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always_comb y_in = pat[sel];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every valid pulse is one transaction.
    always @(negedge clk) begin
        if (valid) begin
            exp_t e;
            chk("valid_gap", {31'd0, prev_valid}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("txn: data_out=%02h expected=%02h at cyc %0d (expected cyc %0d)",
                         data_out, e.data, cyc, e.cyc);
                chk("data_out", {24'd0, data_out}, {24'd0, e.data});
                chk("valid_cycle", cyc, e.cyc);
            end
        end
        prev_valid = valid;
    end

    // One non-continuous scan, checking sel and busy on every cycle.
    // disturb=1 pulses start and flips ch_mask while busy.
    task automatic run_scan(input logic [7:0] m, input logic [7:0] p, input bit disturb);
        int   chs[$];
        int   acc;
        int   L;
        exp_t e;
        for (int i = 0; i < 8; i++) if (m[i]) chs.push_back(i);
        L = chs.size() * STEP + 1;
        pat = p;
        ch_mask = m;
        start = 1'b1;
        acc = cyc;
        e.data = m & p;
        e.cyc = acc + L;
        sb_q.push_back(e);
        for (int j = 1; j <= L + 1; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (disturb && j == 2) begin
                start = 1'b1;
                ch_mask = ~m;
            end
            if (j < L) chk("sel_step", {29'd0, sel}, chs[(j - 1) / STEP]);
            if (j <= L) chk("busy_high", {31'd0, busy}, 32'd1);
            if (j == L + 1) begin
                chk("busy_low", {31'd0, busy}, 32'd0);
                chk("sel_idle", {29'd0, sel}, 32'd0);
            end
        end
        chk("sb_drained", sb_q.size(), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   acc;

        repeat (2) @(negedge clk);
        chk("rst_sel", {29'd0, sel}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_scan(8'hFF, 8'hA5, 1'b0);
        run_scan(8'h81, 8'hFF, 1'b0);
        run_scan(8'h00, 8'hFF, 1'b0);
        run_scan(8'h36, 8'hF0, 1'b1);

        // Continuous mode: two back-to-back scans, pattern changes after the first valid.
        cont = 1'b1;
        ch_mask = 8'h0F;
        pat = 8'h03;
        start = 1'b1;
        acc = cyc;
        e.data = 8'h03; e.cyc = acc + 13; sb_q.push_back(e);
        e.data = 8'h0C; e.cyc = acc + 26; sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        pat = 8'h0C;
        @(negedge clk);
        chk("cont_busy", {31'd0, busy}, 32'd1);
        cont = 1'b0;
        repeat (13) @(negedge clk);
        chk("cont_busy_low", {31'd0, busy}, 32'd0);
        chk("cont_sb_drained", sb_q.size(), 32'd0);

        // Asynchronous reset during the settle of channel 4.
        ch_mask = 8'hFF;
        pat = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && sel != 3'd4; i++) @(negedge clk);
        chk("reach_ch4", {29'd0, sel}, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", {29'd0, sel}, 32'd0);
        chk("arst_data", {24'd0, data_out}, 32'd0);
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_scan(8'hFF, 8'h3C, 1'b0);

        repeat (3) @(negedge clk);
        chk("final_sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
